// File: rtl/xmem_rr_arbiter_if.sv
`timescale 1ns/1ps
// xmem bus bundle: NP request lanes with packed payload, scalar broadcast response.
// Latency: none, wires only.
// Backpressure: req/payload held by the master until gnt, response is a one-cycle pulse.
// Ports: req, addr, we, wdata, be (master->slave); gnt, rsp_valid, rsp_rdata, rsp_error (slave->master).
interface xmem_rr_arbiter_if #(
    parameter int NP = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [NP-1:0]        req;
    logic [NP*AW-1:0]     addr;
    logic [NP-1:0]        we;
    logic [NP*DW-1:0]     wdata;
    logic [NP*DW/8-1:0]   be;
    logic [NP-1:0]        gnt;
    logic [NP-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_error;

    modport master (
        output req, addr, we, wdata, be,
        input  gnt, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req, addr, we, wdata, be,
        output gnt, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/xmem_rr_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one xmem slave between NUM_PORTS masters, one transaction in flight.
// Latency: 1 arbitration cycle (IDLE) before the request reaches the slave; gnt/rsp pass through combinationally.
// Backpressure: winner's req waits for m_xmem.gnt; others wait until the winner's response has returned.
// Ports: aclk, areset (sync, active-high); s_xmem (NUM_PORTS masters side), m_xmem (slave side); arb_busy.
// Optional: define XMEM_ARB_TIMEOUT_EN for a TIMEOUT_CYCLES response timeout with a DRAIN state.
module xmem_rr_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int XADDR_WIDTH    = 32,
    parameter int XDATA_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int SEL_W          = $clog2(NUM_PORTS)
) (
    input  logic              aclk,
    input  logic              areset,
    xmem_rr_arbiter_if.slave  s_xmem,
    xmem_rr_arbiter_if.master m_xmem,
    output logic              arb_busy
);
    localparam int BE_W = XDATA_WIDTH / 8;

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("xmem_rr_arbiter: NUM_PORTS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

`ifdef XMEM_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP, ST_DRAIN} state_t;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;
`endif

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;
    logic [SEL_W-1:0] last, last_nxt;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W:0]   cand;

    // Priority scan starts just after the last served port and wraps, so the
    // port served most recently is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = {1'b0, last} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(NUM_PORTS)) begin
                cand = cand - (SEL_W+1)'(NUM_PORTS);
            end
            if (!win_found && s_xmem.req[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
            sel   <= '0;
            last  <= SEL_W'(NUM_PORTS - 1);
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
        end
    end

`ifdef XMEM_ARB_TIMEOUT_EN
    // Counts RSP cycles; held at zero outside RSP so it starts clean on entry.
    always_ff @(posedge aclk) begin
        if (areset || state != ST_RSP) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt          = state;
        sel_nxt            = sel;
        last_nxt           = last;
        m_xmem.req         = '0;
        m_xmem.addr        = '0;
        m_xmem.we          = '0;
        m_xmem.wdata       = '0;
        m_xmem.be          = '0;
        s_xmem.gnt         = '0;
        s_xmem.rsp_valid   = '0;
        s_xmem.rsp_rdata   = m_xmem.rsp_rdata;
        s_xmem.rsp_error   = m_xmem.rsp_error;

        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    sel_nxt   = win_idx;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                m_xmem.req[0] = s_xmem.req[sel];
                m_xmem.addr   = s_xmem.addr[sel*XADDR_WIDTH +: XADDR_WIDTH];
                m_xmem.we[0]  = s_xmem.we[sel];
                m_xmem.wdata  = s_xmem.wdata[sel*XDATA_WIDTH +: XDATA_WIDTH];
                m_xmem.be     = s_xmem.be[sel*BE_W +: BE_W];
                if (!s_xmem.req[sel]) begin
                    // Abort before grant: nothing was consumed, priority untouched.
                    state_nxt = ST_IDLE;
                end else if (m_xmem.gnt[0]) begin
                    s_xmem.gnt[sel] = 1'b1;
                    if (m_xmem.rsp_valid[0]) begin
                        s_xmem.rsp_valid[sel] = 1'b1;
                        last_nxt              = sel;
                        state_nxt             = ST_IDLE;
                    end else begin
                        state_nxt = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (m_xmem.rsp_valid[0]) begin
                    s_xmem.rsp_valid[sel] = 1'b1;
                    last_nxt              = sel;
                    state_nxt             = ST_IDLE;
                end
`ifdef XMEM_ARB_TIMEOUT_EN
                else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    // Synthesised error response; the real one is swallowed in DRAIN.
                    s_xmem.rsp_valid[sel] = 1'b1;
                    s_xmem.rsp_error      = 1'b1;
                    s_xmem.rsp_rdata      = '0;
                    last_nxt              = sel;
                    state_nxt             = ST_DRAIN;
                end
`endif
            end
`ifdef XMEM_ARB_TIMEOUT_EN
            ST_DRAIN: begin
                if (m_xmem.rsp_valid[0]) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign arb_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_xmem_rr_arbiter.sv
`timescale 1ns/1ps
// Testbench for xmem_rr_arbiter: directed scenarios plus randomized traffic against an ownership/priority model.
// Inputs change on the falling edge, outputs are sampled shortly after, state advances on the rising edge.
module tb_xmem_rr_arbiter;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic aclk = 1'b0;
    logic areset;
    logic arb_busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    xmem_rr_arbiter_if #(.NP(NP), .AW(AW), .DW(DW)) s_bus ();
    xmem_rr_arbiter_if #(.NP(1),  .AW(AW), .DW(DW)) m_bus ();

    xmem_rr_arbiter #(
        .NUM_PORTS(NP), .XADDR_WIDTH(AW), .XDATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk(aclk), .areset(areset), .s_xmem(s_bus), .m_xmem(m_bus), .arb_busy(arb_busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        s_bus.req           = '0;
        s_bus.addr          = '0;
        s_bus.we            = '0;
        s_bus.wdata         = '0;
        s_bus.be            = '0;
        m_bus.gnt           = '0;
        m_bus.rsp_valid     = '0;
        m_bus.rsp_rdata     = '0;
        m_bus.rsp_error     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        areset = 1'b1;
        idle_inputs();
        s_bus.req = '1;
        s_bus.addr = {32'h0000_0010, 32'h0000_0020};
        m_bus.gnt = 1'b1;
        m_bus.rsp_valid = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", arb_busy); end
        n_checks++; if (m_bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_mreq got %b want 0", m_bus.req); end
        n_checks++; if (m_bus.addr !== '0) begin n_fail++; $display("FAIL reset_maddr got %h want 0", m_bus.addr); end
        n_checks++; if (s_bus.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_sgnt got %b want 00", s_bus.gnt); end
        n_checks++; if (s_bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_srsp got %b want 00", s_bus.rsp_valid); end
        @(negedge aclk);
        areset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_write();
        do_reset();
        s_bus.req[0] = 1'b1; s_bus.addr[0 +: AW] = 32'h0; s_bus.we[0] = 1'b1;
        s_bus.wdata[0 +: DW] = 32'h0123_4567; s_bus.be[0 +: BW] = 4'hF;
        #1;
        n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_busy got %b want 0", arb_busy); end
        @(negedge aclk); m_bus.gnt = 1'b1; #1;
        n_checks++; if (m_bus.req !== 1'b1) begin n_fail++; $display("FAIL wr_mreq got %b want 1", m_bus.req); end
        n_checks++; if (m_bus.addr !== 32'h0 || m_bus.be !== 4'hF || m_bus.we !== 1'b1 || m_bus.wdata !== 32'h0123_4567) begin
            n_fail++; $display("FAIL wr_payload got addr=%h be=%h we=%b wd=%h want 0/F/1/01234567", m_bus.addr, m_bus.be, m_bus.we, m_bus.wdata); end
        n_checks++; if (s_bus.gnt !== 2'b01) begin n_fail++; $display("FAIL wr_sgnt got %b want 01", s_bus.gnt); end
        @(negedge aclk); m_bus.gnt = 1'b0; #1;
        n_checks++; if (m_bus.req !== 1'b0 || s_bus.gnt !== 2'b00 || arb_busy !== 1'b1) begin
            n_fail++; $display("FAIL wr_rsp_wait got mreq=%b sgnt=%b busy=%b want 0/00/1", m_bus.req, s_bus.gnt, arb_busy); end
        @(negedge aclk); m_bus.rsp_valid = 1'b1; #1;
        n_checks++; if (s_bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL wr_srsp got %b want 01", s_bus.rsp_valid); end
        @(negedge aclk); idle_inputs(); #1;
        n_checks++; if (arb_busy !== 1'b0 || s_bus.rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL wr_after got busy=%b srsp=%b want 0/00", arb_busy, s_bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int  grants = 0;
        int  idle_run = 0;
        bit  pend = 0;
        do_reset();
        s_bus.req = 2'b11;
        s_bus.addr = {32'h0000_0104, 32'h0000_0100};
        s_bus.be = '1;
        for (int cyc = 0; cyc < 60 && grants < 8; cyc++) begin
            if (cyc > 0) @(negedge aclk);
            m_bus.rsp_valid = pend;
            m_bus.gnt = 1'b0;
            pend = 1'b0;
            #1;
            m_bus.gnt = m_bus.req;
            pend = m_bus.req[0];
            #1;
            if (s_bus.gnt != 2'b00) begin
                n_checks++;
                if (s_bus.gnt !== ((grants % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL b2b_order txn %0d got %b want %b", grants, s_bus.gnt, (grants % 2 == 0) ? 2'b01 : 2'b10);
                end
                grants++;
            end
            if (arb_busy === 1'b0) begin
                idle_run++;
            end else if (idle_run > 0) begin
                n_checks++;
                if (idle_run !== 1) begin n_fail++; $display("FAIL b2b_idle_gap got %0d want 1", idle_run); end
                idle_run = 0;
            end
        end
        n_checks++; if (grants !== 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", grants); end
        @(negedge aclk); m_bus.rsp_valid = pend; m_bus.gnt = 1'b0;
        @(negedge aclk); idle_inputs();
    endtask

    task automatic test_same_cycle_rsp();
        do_reset();
        s_bus.req[1] = 1'b1; s_bus.addr[AW +: AW] = 32'h8; s_bus.we[1] = 1'b0; s_bus.be[BW +: BW] = 4'hF;
        @(negedge aclk);
        m_bus.gnt = 1'b1; m_bus.rsp_valid = 1'b1; m_bus.rsp_rdata = 32'hfedc_ba98; #1;
        n_checks++; if (m_bus.addr !== 32'h8 || m_bus.we !== 1'b0) begin
            n_fail++; $display("FAIL rd_payload got addr=%h we=%b want 8/0", m_bus.addr, m_bus.we); end
        n_checks++; if (s_bus.gnt !== 2'b10 || s_bus.rsp_valid !== 2'b10) begin
            n_fail++; $display("FAIL rd_same_cycle got gnt=%b rsp=%b want 10/10", s_bus.gnt, s_bus.rsp_valid); end
        n_checks++; if (s_bus.rsp_rdata !== 32'hfedc_ba98) begin
            n_fail++; $display("FAIL rd_rdata got %h want fedcba98", s_bus.rsp_rdata); end
        @(negedge aclk); idle_inputs(); #1;
        n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL rd_back_idle got %b want 0", arb_busy); end
    endtask

    task automatic test_abort();
        do_reset();
        s_bus.req = 2'b11; s_bus.addr = {32'h0000_0200, 32'h0000_0300}; s_bus.be = '1;
        @(negedge aclk); #1;
        n_checks++; if (m_bus.req !== 1'b1 || m_bus.addr !== 32'h300) begin
            n_fail++; $display("FAIL abort_req got mreq=%b addr=%h want 1/300", m_bus.req, m_bus.addr); end
        @(negedge aclk); s_bus.req[0] = 1'b0; #1;
        n_checks++; if (m_bus.req !== 1'b0 || s_bus.gnt !== 2'b00) begin
            n_fail++; $display("FAIL abort_drop got mreq=%b sgnt=%b want 0/00", m_bus.req, s_bus.gnt); end
        @(negedge aclk); #1;
        n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b want 0", arb_busy); end
        @(negedge aclk); m_bus.gnt = 1'b1; #1;
        n_checks++; if (s_bus.gnt !== 2'b10) begin n_fail++; $display("FAIL abort_next_gnt got %b want 10", s_bus.gnt); end
        @(negedge aclk); m_bus.gnt = 1'b0; m_bus.rsp_valid = 1'b1; #1;
        n_checks++; if (s_bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL abort_next_rsp got %b want 10", s_bus.rsp_valid); end
        @(negedge aclk); m_bus.rsp_valid = 1'b0; s_bus.req = 2'b11;
        @(negedge aclk); m_bus.gnt = 1'b1; #1;
        n_checks++; if (s_bus.gnt !== 2'b01) begin n_fail++; $display("FAIL abort_prio got %b want 01", s_bus.gnt); end
        @(negedge aclk); m_bus.gnt = 1'b0; m_bus.rsp_valid = 1'b1;
        @(negedge aclk); idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_bus.req[0] = 1'b1; s_bus.addr = {32'h0000_0500, 32'h0000_0400}; s_bus.be = '1;
        @(negedge aclk); m_bus.gnt = 1'b1;
        @(negedge aclk); m_bus.gnt = 1'b0; m_bus.rsp_valid = 1'b1;
        // port0 served last: without a reset, port1 would be next
        @(negedge aclk); m_bus.rsp_valid = 1'b0;
        @(negedge aclk); m_bus.gnt = 1'b1;
        @(negedge aclk); m_bus.gnt = 1'b0; s_bus.req[1] = 1'b1; areset = 1'b1; #1;
        n_checks++; if (arb_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_rsp got %b want 1", arb_busy); end
        @(negedge aclk); areset = 1'b0; m_bus.rsp_valid = 1'b1; #1;
        n_checks++; if (arb_busy !== 1'b0 || m_bus.req !== 1'b0 || s_bus.rsp_valid !== 2'b00 || s_bus.gnt !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_outputs got busy=%b mreq=%b srsp=%b sgnt=%b want 0/0/00/00", arb_busy, m_bus.req, s_bus.rsp_valid, s_bus.gnt); end
        @(negedge aclk); m_bus.rsp_valid = 1'b0; m_bus.gnt = 1'b1; #1;
        n_checks++; if (s_bus.gnt !== 2'b01 || m_bus.addr !== 32'h400) begin
            n_fail++; $display("FAIL rstmid_winner got gnt=%b addr=%h want 01/400", s_bus.gnt, m_bus.addr); end
        @(negedge aclk); m_bus.gnt = 1'b0; m_bus.rsp_valid = 1'b1;
        @(negedge aclk); idle_inputs();
    endtask

`ifdef XMEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        s_bus.req[0] = 1'b1; s_bus.addr[0 +: AW] = 32'h40; s_bus.be[0 +: BW] = 4'hF;
        @(negedge aclk); m_bus.gnt = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            m_bus.gnt = 1'b0; m_bus.rsp_rdata = 32'hdead_beef;
            #1;
            if (k < 8) begin
                n_checks++; if (s_bus.rsp_valid !== 2'b00) begin
                    n_fail++; $display("FAIL tmo_early cycle %0d got %b want 00", k, s_bus.rsp_valid); end
            end else begin
                n_checks++; if (s_bus.rsp_valid !== 2'b01 || s_bus.rsp_error !== 1'b1 || s_bus.rsp_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL tmo_fire got rsp=%b err=%b rdata=%h want 01/1/0", s_bus.rsp_valid, s_bus.rsp_error, s_bus.rsp_rdata); end
            end
        end
        @(negedge aclk); s_bus.req = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (arb_busy !== 1'b1 || m_bus.req !== 1'b0) begin
                n_fail++; $display("FAIL tmo_drain got busy=%b mreq=%b want 1/0", arb_busy, m_bus.req); end
            @(negedge aclk);
        end
        m_bus.rsp_valid = 1'b1; #1;
        n_checks++; if (s_bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL tmo_late_rsp got %b want 00", s_bus.rsp_valid); end
        @(negedge aclk); m_bus.rsp_valid = 1'b0; #1;
        n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle got %b want 0", arb_busy); end
        @(negedge aclk); idle_inputs();
    endtask
`endif

    // Model: an owner (or none) plus the index of the last served port; the winner
    // is the first requester at (last+1), (last+2), ... modulo NP.
    task automatic test_random();
        int   owner = -1;
        bit   granted = 1'b0;
        int   last_m = NP - 1;
        bit   act[NP];
        bit   gtd[NP];
        bit   done[NP];
        logic [AW-1:0] addr_m[NP];
        bit   s_out = 1'b0;
        int   s_cnt = 0;
        int   d;
        logic [NP-1:0] exp_g, exp_r, req_now;
        logic exp_mreq, exp_busy;
        logic [AW-1:0] exp_addr;
        int   owner_n;
        bit   granted_n;
        do_reset();
        for (int p = 0; p < NP; p++) begin act[p] = 0; gtd[p] = 0; done[p] = 0; addr_m[p] = '0; end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc > 0) @(negedge aclk);
            for (int p = 0; p < NP; p++) begin
                if (done[p]) begin act[p] = 0; done[p] = 0; end
                if (!act[p] && $urandom_range(0, 2) == 0) begin
                    act[p] = 1; gtd[p] = 0;
                    addr_m[p] = $urandom;
                    s_bus.addr[p*AW +: AW] = addr_m[p];
                    s_bus.wdata[p*DW +: DW] = $urandom;
                    s_bus.we[1'(p)] = 1'($urandom_range(0, 1));
                    s_bus.be[p*BW +: BW] = 4'($urandom_range(0, 15));
                end else if (act[p] && !gtd[p] && $urandom_range(0, 15) == 0) begin
                    act[p] = 0;
                end
                s_bus.req[1'(p)] = act[p];
            end
            m_bus.gnt = 1'b0;
            m_bus.rsp_valid = 1'b0;
            m_bus.rsp_rdata = $urandom;
            m_bus.rsp_error = 1'($urandom_range(0, 1));
            if (s_out) begin
                if (s_cnt == 0) begin m_bus.rsp_valid = 1'b1; s_out = 0; end
                else s_cnt--;
            end
            #1;
            if (m_bus.req[0] === 1'b1 && $urandom_range(0, 1) == 1) begin
                m_bus.gnt = 1'b1;
                d = $urandom_range(0, 3);
                if (d == 0) m_bus.rsp_valid = 1'b1;
                else begin s_out = 1; s_cnt = d - 1; end
            end
            #1;
            req_now = s_bus.req;
            exp_busy = (owner >= 0);
            exp_mreq = 1'b0; exp_g = '0; exp_r = '0; exp_addr = '0;
            owner_n = owner; granted_n = granted;
            if (owner < 0) begin
                for (int k = 1; k <= NP; k++) begin
                    if (owner_n < 0 && req_now[1'((last_m + k) % NP)]) owner_n = (last_m + k) % NP;
                end
                granted_n = 0;
            end else if (!granted) begin
                exp_mreq = req_now[1'(owner)];
                exp_addr = addr_m[owner];
                if (!exp_mreq) owner_n = -1;
                else if (m_bus.gnt[0]) begin
                    exp_g[1'(owner)] = 1'b1;
                    if (m_bus.rsp_valid[0]) begin exp_r[1'(owner)] = 1'b1; last_m = owner; owner_n = -1; end
                    else granted_n = 1;
                end
            end else if (m_bus.rsp_valid[0]) begin
                exp_r[1'(owner)] = 1'b1; last_m = owner; owner_n = -1;
            end
            n_checks++; if (arb_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, arb_busy, exp_busy); end
            n_checks++; if (m_bus.req[0] !== exp_mreq) begin n_fail++; $display("FAIL rnd_mreq cyc %0d got %b want %b", cyc, m_bus.req, exp_mreq); end
            if (exp_mreq) begin
                n_checks++; if (m_bus.addr !== exp_addr) begin n_fail++; $display("FAIL rnd_maddr cyc %0d got %h want %h", cyc, m_bus.addr, exp_addr); end
            end
            n_checks++; if (s_bus.gnt !== exp_g) begin n_fail++; $display("FAIL rnd_sgnt cyc %0d got %b want %b", cyc, s_bus.gnt, exp_g); end
            n_checks++; if (s_bus.rsp_valid !== exp_r) begin n_fail++; $display("FAIL rnd_srsp cyc %0d got %b want %b", cyc, s_bus.rsp_valid, exp_r); end
            n_checks++; if (s_bus.rsp_rdata !== m_bus.rsp_rdata || s_bus.rsp_error !== m_bus.rsp_error) begin
                n_fail++; $display("FAIL rnd_passthru cyc %0d got %h/%b want %h/%b", cyc, s_bus.rsp_rdata, s_bus.rsp_error, m_bus.rsp_rdata, m_bus.rsp_error); end
            for (int p = 0; p < NP; p++) begin
                if (exp_g[1'(p)]) gtd[p] = 1;
                if (exp_r[1'(p)]) done[p] = 1;
            end
            owner = owner_n; granted = granted_n;
        end
        @(negedge aclk); idle_inputs();
    endtask

    initial begin
        areset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_same_cycle_rsp();
        test_abort();
        test_reset_mid();
`ifdef XMEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xmem_rr_arbiter.md
Name: xmem_rr_arbiter

Overview:
Round-robin arbiter sharing one xmem slave port (typically an xmem_to_bram bridge) between NUM_PORTS xmem masters, e.g. core instruction and data ports plus a DMA.
- One transaction outstanding at a time; the winner holds the downstream port from request to response.
- Sits directly upstream of the bridge: masters on the s_ side, bridge on the m_ side.
- Payload is muxed downstream; the response is routed back to the winner only.

Parameters:
NUM_PORTS, 2, number of upstream masters (2..8)
XADDR_WIDTH, 32, xmem address width
XDATA_WIDTH, 32, xmem data width (be width = XDATA_WIDTH/8)
TIMEOUT_CYCLES, 256, response timeout; used only with XMEM_ARB_TIMEOUT_EN
SEL_W, $clog2(NUM_PORTS), derived index width

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous active-high reset
s_xmem_req  in  NUM_PORTS  per-master request
s_xmem_addr  in  NUM_PORTS*XADDR_WIDTH  packed addresses, port i at [i*XADDR_WIDTH +: XADDR_WIDTH]
s_xmem_we  in  NUM_PORTS  write enable
s_xmem_wdata  in  NUM_PORTS*XDATA_WIDTH  packed write data
s_xmem_be  in  NUM_PORTS*XDATA_WIDTH/8  packed byte enables
s_xmem_gnt  out  NUM_PORTS  one-hot grant pulse
s_xmem_rsp_valid  out  NUM_PORTS  one-hot response pulse
s_xmem_rsp_rdata  out  XDATA_WIDTH  read data, broadcast to all ports
s_xmem_rsp_error  out  1  error, broadcast
m_xmem_req / m_xmem_addr / m_xmem_we / m_xmem_wdata / m_xmem_be  out  1/XADDR_WIDTH/1/XDATA_WIDTH/XDATA_WIDTH/8  to slave
m_xmem_gnt  in  1  slave accept
m_xmem_rsp_valid  in  1  slave response pulse
m_xmem_rsp_rdata  in  XDATA_WIDTH  slave read data
m_xmem_rsp_error  in  1  slave error
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock/reset: one clock, aclk. areset is synchronous, active-high.
- Master protocol: a master holds req and its payload stable until its own rsp_valid pulse. Dropping req before gnt aborts that request.
- Reset state:
  - FSM = IDLE, sel = 0, last = NUM_PORTS-1, so port 0 has first priority.
  - All s_/m_ outputs are 0; arb_busy = 0.
- FSM states: IDLE, REQ, RSP (plus DRAIN with the optional feature).
- IDLE:
  - If any s_xmem_req is set, pick the first set bit scanning last+1, last+2, ... with wrap modulo NUM_PORTS.
  - Register the winner into sel and go to REQ next cycle. This costs 1 arbitration cycle.
  - m_xmem_rsp_valid arriving in IDLE is ignored.
- REQ:
  - m_xmem_req = s_xmem_req[sel]. m_ payload is muxed combinationally from port sel.
  - m_xmem_gnt=1: s_xmem_gnt[sel]=1 in the same cycle; go to RSP.
  - m_xmem_gnt and m_xmem_rsp_valid in the same cycle: deliver the response this cycle, set last<=sel, go to IDLE.
  - s_xmem_req[sel] drops before gnt: go to IDLE; last is unchanged.
- RSP:
  - m_xmem_req = 0.
  - On m_xmem_rsp_valid: s_xmem_rsp_valid[sel]=1 and rdata/error pass through combinationally; set last<=sel; go to IDLE.
  - A master dropping req in RSP does not cancel the transaction; its response is still delivered.
- Response and grant rules:
  - s_xmem_rsp_rdata/error equal the m_ inputs at all times; masters qualify them with their own rsp_valid.
  - Never more than one s_xmem_gnt bit or one s_xmem_rsp_valid bit high.
  - Fairness: back-to-back requesters alternate, so no master waits more than NUM_PORTS-1 transactions.
- Reset mid-transaction: return to IDLE immediately, m_xmem_req drops, the in-flight response is discarded. Issuing areset together with the slave is the integration's responsibility.

Optional Feature:
- Macro: XMEM_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to RSP and increments each RSP cycle.
  - At TIMEOUT_CYCLES without m_xmem_rsp_valid: s_xmem_rsp_valid[sel]=1, error=1, rdata=0; last<=sel; go to DRAIN.
  - DRAIN holds arbitration (arb_busy=1) until one late m_xmem_rsp_valid arrives, discards it, then goes to IDLE.
- Without the macro: no counter and no DRAIN state; RSP waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
1. After reset, port0 writes 0x01234567 to addr 0x0; slave gnt on cycle 1, rsp on cycle 3 -> m_xmem_addr=0x0, be=0xF, s_xmem_gnt=01, s_xmem_rsp_valid=01, no pulse on port1.
2. Both ports hold req continuously, 4 transactions each -> grant order 0,1,0,1,... and arb_busy low exactly 1 cycle between transactions.
3. Port1 reads 0x8 and the slave returns 0xfedcba98 with gnt and rsp_valid in the same cycle -> s_xmem_rsp_valid=10 that cycle, rdata=0xfedcba98, FSM back to IDLE next cycle.
4. Port0 drops req while in REQ before gnt; port1 is requesting -> no m_ gnt consumed, port1 granted next, then port0 still has priority after port1.
5. areset asserted in RSP -> next cycle all outputs 0, the late slave rsp_valid is ignored, and port0 wins the next arbitration.
6. (XMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) slave never responds -> on RSP cycle 8 port0 sees rsp_valid with error=1 and rdata=0, arb_busy stays high until one late rsp_valid is injected, then IDLE.
